pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Tracks destination registers of in-flight instructions in a 3-entry stage scoreboard (EX, MEM, WB).
- Detects RAW and load-use hazards against the instruction currently in ID.
- Drives PC/IF-ID enables, ID/EX bubble insertion, branch flush and EX operand-forwarding selects.
- Sits beside the decode stage and register file.

Parameters:
- XLEN, 32, instruction width.
- RADDR_W, 5, register-address width.

Ports:
- clk_sys_i  in  1  system clock, rising edge.
- rst_sys_n_i  in  1  synchronous reset, active-low.
- id_valid_i  in  1  ID stage holds a valid instruction.
- id_instr_i  in  XLEN  instruction currently in ID.
- ex_branch_taken_i  in  1  EX resolved a taken branch/jump. Held stable while mem_ready_i=0.
- mem_ready_i  in  1  data memory ready. 0 freezes the whole pipeline.
- pc_en_o  out  1  PC update enable.
- if_id_en_o  out  1  IF/ID register load enable.
- if_id_flush_o  out  1  clear IF/ID to NOP.
- id_ex_bubble_o  out  1  load NOP into ID/EX instead of the ID instruction.
- fwd_a_sel_o  out  2  EX operand-A source: 0 regfile, 1 EX/MEM result, 2 MEM/WB result.
- fwd_b_sel_o  out  2  EX operand-B source, same encoding.
- stall_cnt_o  out  32  count of cycles with id_ex_bubble_o=1 from a hazard stall, wrapping.

Behaviour:
Clock and reset (already decided):
- Single clock clk_sys_i.
- rst_sys_n_i is synchronous, active-low.

Reset:
- All scoreboard entries invalid; fwd selects 0; stall_cnt_o 0.
- Asserting reset mid-stall or mid-freeze clears everything at the next edge.
- Combinational outputs after reset: pc_en_o=1, if_id_en_o=1, others 0.

ID decode:
- R, S, B use rs1 and rs2.
- I-ALU, LOAD, JALR use rs1 only.
- LUI, AUIPC, JAL use neither.
- R, I-ALU, LOAD, JALR, LUI, AUIPC, JAL write rd.
- A register match is a hazard only if the source is used, rd != x0 and the entry is valid.

Scoreboard entry: {valid, rd, wen, is_load}.
- Each normal cycle it shifts ID->EX->MEM->WB.
- A bubble or flush inserts valid=0 into EX.

Priority, evaluated combinationally each cycle:
1. FREEZE (mem_ready_i=0): pc_en_o=0, if_id_en_o=0, no bubble, no flush. Scoreboard and fwd registers hold.
2. FLUSH (ex_branch_taken_i=1): if_id_flush_o=1, id_ex_bubble_o=1, pc_en_o=1. Overrides any stall. Not counted in stall_cnt_o.
3. STALL: pc_en_o=0, if_id_en_o=0, id_ex_bubble_o=1, stall_cnt_o increments.
4. RUN: all enables 1.

Hazard condition: a used source in ID matches a load in EX.
- Stall exactly 1 cycle; the next cycle the producer is in MEM, giving fwd=2.

Forwarding selects:
- Registered on the ID->EX transfer, so they are valid while the consumer is in EX.
- Compared against the EX entry (code 1) and the MEM entry (code 2). EX has priority when both match.
- A load in MEM forwards with code 2 after its bubble.
- The register file is write-first, so a WB/ID overlap needs no action.
- On a bubble, both selects load 0.

id_valid_i=0 means no sources and no rd; ID is treated as a NOP.

Optional Feature:
Macro PIPE_HAZARD_FWD_EN.
- Defined: forwarding exactly as above.
- Undefined:
  - fwd_a_sel_o and fwd_b_sel_o are tied to 0.
  - STALL asserts while any used ID source matches a valid writing entry in EX or MEM, whether load or not.
  - Back-to-back dependent ALU ops stall 2 cycles; load-use stalls 2 cycles.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2.
  - Scoreboard entry struct width constants.
- Opcode constants are reused from the shared RISC-V instruction-definition header.
- Sub-module pipe_ctrl_dec: combinational decode of id_instr_i into uses_rs1, uses_rs2, writes_rd, is_load, rs1, rs2, rd.

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3 -> no stall; sub in EX with fwd_a_sel_o=1, fwd_b_sel_o=0. Undefined macro: 2 bubbles, stall_cnt_o=2.
- lw x5,0(x1) then add x6,x5,x5 -> 1 cycle pc_en_o=0, id_ex_bubble_o=1; then add in EX with fwd_a=fwd_b=2; stall_cnt_o=1.
- addi x0,x1,1 then add x2,x0,x0 -> no stall, fwd selects 0.
- beq taken in EX while lw-use hazard present in ID -> if_id_flush_o=1, id_ex_bubble_o=1, pc_en_o=1, stall_cnt_o unchanged.
- mem_ready_i=0 for 3 cycles during a dependent sequence -> pc_en_o=if_id_en_o=0 for 3 cycles, fwd selects held, same results after release.
- rst_sys_n_i=0 for one cycle during a load-use stall -> next cycle all entries invalid, pc_en_o=1, stall_cnt_o=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: forwarding
// codes, RV32I opcodes, the stage scoreboard entry and its match helpers.
package pipe_ctrl_pkg;

  // EX operand source encodings
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  // RV32I major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Scoreboard entry layout
  localparam int SB_RD_W    = 5;
  localparam int SB_ENTRY_W = 1 + SB_RD_W + 1 + 1;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               wen;
    logic               is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  // True when a used, non-x0 source reads the register this entry writes
  function automatic logic src_hit(sb_entry_t e, logic used, logic [SB_RD_W-1:0] rs);
    return used && (rs != '0) && e.valid && e.wen && (e.rd == rs);
  endfunction

  // Forwarding source for one operand; the younger (EX) producer wins
  function automatic logic [1:0] fwd_pick(sb_entry_t ex, sb_entry_t mem, logic used,
                                          logic [SB_RD_W-1:0] rs);
    if (src_hit(ex, used, rs))       return FWD_EXMEM;
    else if (src_hit(mem, used, rs)) return FWD_MEMWB;
    else                             return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-side handshake bundle of the pipeline hazard controller.
// master: pipeline/decode side driving ID state; slave: the controller.
interface pipe_hazard_ctrl_if #(
  parameter int XLEN = 32
);
  logic            id_valid_i;
  logic [XLEN-1:0] id_instr_i;
  logic            ex_branch_taken_i;
  logic            mem_ready_i;
  logic            pc_en_o;
  logic            if_id_en_o;
  logic            if_id_flush_o;
  logic            id_ex_bubble_o;
  logic [1:0]      fwd_a_sel_o;
  logic [1:0]      fwd_b_sel_o;
  logic [31:0]     stall_cnt_o;

  modport master (
    output id_valid_i, id_instr_i, ex_branch_taken_i, mem_ready_i,
    input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_bubble_o,
           fwd_a_sel_o, fwd_b_sel_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_instr_i, ex_branch_taken_i, mem_ready_i,
    output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_bubble_o,
           fwd_a_sel_o, fwd_b_sel_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_dec.sv
// Combinational decode of the ID instruction into register usage.
// An invalid ID slot decodes as a NOP (no sources, no destination).
module pipe_ctrl_dec
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               valid,
  input  logic [XLEN-1:0]    instr,
  output logic               uses_rs1,
  output logic               uses_rs2,
  output logic               writes_rd,
  output logic               is_load,
  output logic [RADDR_W-1:0] rs1,
  output logic [RADDR_W-1:0] rs2,
  output logic [RADDR_W-1:0] rd
);

  logic [6:0] opcode;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign rd           = instr[7 +: RADDR_W];
  assign rs1          = instr[15 +: RADDR_W];
  assign rs2          = instr[20 +: RADDR_W];
  assign unused_instr = ^{instr[14:12], instr[XLEN-1:25]};

  // Opcode class to source/destination usage
  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    if (valid) begin
      case (opcode)
        OP_R:                  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
        OP_STORE, OP_BRANCH:   begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
        OP_I_ALU, OP_JALR:     begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
        OP_LOAD:               begin uses_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1; end
        OP_LUI, OP_AUIPC,
        OP_JAL:                writes_rd = 1'b1;
        default:               ;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core.
// Keeps an EX/MEM/WB destination scoreboard, detects hazards against ID and
// drives PC/IF-ID enables, ID/EX bubbles, branch flush and EX forwarding.
// Optional macro PIPE_HAZARD_FWD_EN: when defined, EX forwarding is enabled
// and only load-use stalls; otherwise selects are tied to the register file
// and any RAW against EX or MEM stalls.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = SB_RD_W
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_n_i,
  pipe_hazard_ctrl_if.slave bus
);

  logic               uses_rs1, uses_rs2, writes_rd, is_load;
  logic [RADDR_W-1:0] rs1, rs2, rd;

  pipe_ctrl_dec #(
    .XLEN    (XLEN),
    .RADDR_W (RADDR_W)
  ) u_dec (
    .valid     (bus.id_valid_i),
    .instr     (bus.id_instr_i),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .writes_rd (writes_rd),
    .is_load   (is_load),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd)
  );

  // Scoreboard: _p0 = EX, _p1 = MEM, _p2 = WB
  sb_entry_t   sb_p0, sb_p1, sb_p2;
  sb_entry_t   id_entry;
  logic        hazard;
  logic        freeze, flush, stall_hit;
  logic        pc_en, if_id_en, if_id_flush, bubble;
  logic [31:0] stall_cnt;
  logic        unused_sb;

  assign id_entry = '{valid:   bus.id_valid_i,
                      rd:      rd,
                      wen:     writes_rd && (rd != '0),
                      is_load: is_load};

  // WB entry is kept for completeness; the write-first regfile never needs it
  assign unused_sb = ^{sb_p2, sb_p1.is_load};

`ifdef PIPE_HAZARD_FWD_EN
  // Only a load still in EX cannot be forwarded in time
  assign hazard = sb_p0.is_load &&
                  (src_hit(sb_p0, uses_rs1, rs1) || src_hit(sb_p0, uses_rs2, rs2));
`else
  // Without forwarding, wait until producers have left MEM
  assign hazard = src_hit(sb_p0, uses_rs1, rs1) || src_hit(sb_p0, uses_rs2, rs2) ||
                  src_hit(sb_p1, uses_rs1, rs1) || src_hit(sb_p1, uses_rs2, rs2);
`endif

  assign freeze    = !bus.mem_ready_i;
  assign flush     = bus.ex_branch_taken_i;
  assign stall_hit = !freeze && !flush && hazard;

  // Priority: freeze, then branch flush, then hazard stall, else run
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    bubble      = 1'b0;
    if (freeze) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
    end else if (flush) begin
      if_id_flush = 1'b1;
      bubble      = 1'b1;
    end else if (hazard) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      bubble   = 1'b1;
    end
  end

  // Scoreboard shift ID->EX->MEM->WB and hazard-stall counter
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_n_i) begin
      sb_p0     <= SB_EMPTY;
      sb_p1     <= SB_EMPTY;
      sb_p2     <= SB_EMPTY;
      stall_cnt <= '0;
    end else if (!freeze) begin
      sb_p0 <= bubble ? SB_EMPTY : id_entry;
      sb_p1 <= sb_p0;
      sb_p2 <= sb_p1;
      if (stall_hit) stall_cnt <= stall_cnt + 32'd1;
    end
  end

`ifdef PIPE_HAZARD_FWD_EN
  logic [1:0] fwd_a_p0, fwd_b_p0;

  // Forwarding selects captured as the ID instruction moves into EX
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_n_i) begin
      fwd_a_p0 <= FWD_RF;
      fwd_b_p0 <= FWD_RF;
    end else if (!freeze) begin
      if (bubble) begin
        fwd_a_p0 <= FWD_RF;
        fwd_b_p0 <= FWD_RF;
      end else begin
        fwd_a_p0 <= fwd_pick(sb_p0, sb_p1, uses_rs1, rs1);
        fwd_b_p0 <= fwd_pick(sb_p0, sb_p1, uses_rs2, rs2);
      end
    end
  end

  assign bus.fwd_a_sel_o = fwd_a_p0;
  assign bus.fwd_b_sel_o = fwd_b_p0;
`else
  assign bus.fwd_a_sel_o = FWD_RF;
  assign bus.fwd_b_sel_o = FWD_RF;
`endif

  assign bus.pc_en_o        = pc_en;
  assign bus.if_id_en_o     = if_id_en;
  assign bus.if_id_flush_o  = if_id_flush;
  assign bus.id_ex_bubble_o = bubble;
  assign bus.stall_cnt_o    = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table of per-cycle ID vectors
// with expected control outputs, a queue of expected registered results,
// and hand-written reset sequences. Expectations follow PIPE_HAZARD_FWD_EN.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.XLEN(32)) bus ();

  pipe_hazard_ctrl #(.XLEN(32), .RADDR_W(5)) dut (
    .clk_sys_i   (clk),
    .rst_sys_n_i (rst_n),
    .bus         (bus.slave)
  );

  typedef struct {
    bit          vld;
    logic [31:0] instr;
    bit          br;
    bit          rdy;
    bit          pc;
    bit          ifid;
    bit          fl;
    bit          bub;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] cnt;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] run_cnt = 0;

  logic [31:0] ADD5, SUB6, LW5, ADD655, ADDI0, ADD200, NOP, ADD765;

  function automatic logic [31:0] r_type(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                         logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic v(bit vld, logic [31:0] ins, bit br, bit rdy, bit pc, bit ifid,
                   bit fl, bit bub, logic [1:0] fa, logic [1:0] fb);
    vec_t e;
    if (rdy && bub && !fl) run_cnt = run_cnt + 1;
    e = '{vld: vld, instr: ins, br: br, rdy: rdy, pc: pc, ifid: ifid, fl: fl, bub: bub,
          fa: fa, fb: fb, cnt: run_cnt};
    vecs.push_back(e);
  endtask

  task automatic run(logic [31:0] ins, logic [1:0] fa, logic [1:0] fb);
    v(1, ins, 0, 1, 1, 1, 0, 0, fa, fb);
  endtask

  task automatic stl(logic [31:0] ins);
    v(1, ins, 0, 1, 0, 0, 0, 1, 2'd0, 2'd0);
  endtask

  task automatic frz(logic [31:0] ins, logic [1:0] fa, logic [1:0] fb);
    v(1, ins, 0, 0, 0, 0, 0, 0, fa, fb);
  endtask

  task automatic nops(int n);
    for (int k = 0; k < n; k++) run(NOP, 2'd0, 2'd0);
  endtask

  task automatic drive(bit vld, logic [31:0] ins, bit br, bit rdy);
    bus.id_valid_i        = vld;
    bus.id_instr_i        = ins;
    bus.ex_branch_taken_i = br;
    bus.mem_ready_i       = rdy;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t ex;
    ADD5   = r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd5);
    SUB6   = r_type(7'h20, 5'd3, 5'd5, 3'd0, 5'd6);
    LW5    = i_type(12'd0, 5'd1, 3'd2, 5'd5, 7'b0000011);
    ADD655 = r_type(7'h00, 5'd5, 5'd5, 3'd0, 5'd6);
    ADDI0  = i_type(12'd1, 5'd1, 3'd0, 5'd0, 7'b0010011);
    ADD200 = r_type(7'h00, 5'd0, 5'd0, 3'd0, 5'd2);
    NOP    = i_type(12'd0, 5'd0, 3'd0, 5'd0, 7'b0010011);
    ADD765 = r_type(7'h00, 5'd5, 5'd6, 3'd0, 5'd7);

`ifdef PIPE_HAZARD_FWD_EN
    // dependent ALU pair: forwarded from EX/MEM
    run(ADD5, 0, 0); run(SUB6, 1, 0); nops(3);
    // load-use: one bubble then MEM/WB forwarding
    run(LW5, 0, 0); stl(ADD655); run(ADD655, 2, 2); nops(3);
`else
    // dependent ALU pair: two bubbles
    run(ADD5, 0, 0); stl(SUB6); stl(SUB6); run(SUB6, 0, 0); nops(3);
    // load-use: two bubbles
    run(LW5, 0, 0); stl(ADD655); stl(ADD655); run(ADD655, 0, 0); nops(3);
`endif
    // x0 destination never creates a dependency; invalid ID is a NOP
    run(ADDI0, 0, 0); run(ADD200, 0, 0);
    run(LW5, 0, 0); v(0, ADD655, 0, 1, 1, 1, 0, 0, 0, 0); nops(3);
    // taken branch overrides a load-use stall
    run(LW5, 0, 0); v(1, ADD655, 1, 1, 1, 1, 1, 1, 0, 0); run(NOP, 0, 0); nops(2);
`ifdef PIPE_HAZARD_FWD_EN
    // freeze holds selects and scoreboard
    run(ADD5, 0, 0); run(SUB6, 1, 0);
    frz(ADD765, 1, 0); frz(ADD765, 1, 0); frz(ADD765, 1, 0);
    run(ADD765, 1, 2); nops(3);
`else
    // freeze during a pending hazard: no counting, then stall resumes
    run(ADD5, 0, 0);
    frz(SUB6, 0, 0); frz(SUB6, 0, 0); frz(SUB6, 0, 0);
    stl(SUB6); stl(SUB6); run(SUB6, 0, 0); nops(3);
`endif

    // reset state
    rst_n = 1'b0;
    drive(0, 32'd0, 0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst pc_en", bus.pc_en_o, 1);
    chk("rst if_id_en", bus.if_id_en_o, 1);
    chk("rst flush", bus.if_id_flush_o, 0);
    chk("rst bubble", bus.id_ex_bubble_o, 0);
    chk("rst fwd_a", bus.fwd_a_sel_o, 0);
    chk("rst fwd_b", bus.fwd_b_sel_o, 0);
    chk("rst stall_cnt", bus.stall_cnt_o, 0);

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].vld, vecs[i].instr, vecs[i].br, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d pc_en", i), bus.pc_en_o, vecs[i].pc);
      chk($sformatf("v%0d if_id_en", i), bus.if_id_en_o, vecs[i].ifid);
      chk($sformatf("v%0d flush", i), bus.if_id_flush_o, vecs[i].fl);
      chk($sformatf("v%0d bubble", i), bus.id_ex_bubble_o, vecs[i].bub);
      sb_q.push_back('{fa: vecs[i].fa, fb: vecs[i].fb, cnt: vecs[i].cnt});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        chk($sformatf("v%0d queue", i), 0, 1);
      end else begin
        ex = sb_q.pop_front();
        chk($sformatf("v%0d fwd_a", i), bus.fwd_a_sel_o, ex.fa);
        chk($sformatf("v%0d fwd_b", i), bus.fwd_b_sel_o, ex.fb);
        chk($sformatf("v%0d stall_cnt", i), bus.stall_cnt_o, ex.cnt);
      end
    end

    // reset asserted for one cycle during a load-use stall
    @(negedge clk);
    drive(1, LW5, 0, 1);
    @(negedge clk);
    drive(1, ADD655, 0, 1);
    #1;
    chk("rs stall bubble", bus.id_ex_bubble_o, 1);
    chk("rs stall pc_en", bus.pc_en_o, 0);
    chk("rs cnt before", bus.stall_cnt_o, run_cnt);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rs pc_en", bus.pc_en_o, 1);
    chk("rs bubble", bus.id_ex_bubble_o, 0);
    chk("rs stall_cnt", bus.stall_cnt_o, 0);
    chk("rs fwd_a", bus.fwd_a_sel_o, 0);
    @(posedge clk);
    #1;
    chk("rs after cnt", bus.stall_cnt_o, 0);
    chk("rs after fwd_b", bus.fwd_b_sel_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
